// File: rtl/bit_ctrl_bank_if.sv
// Command port of bit_ctrl_bank: valid/ready handshake with opcode, target
// channel, target bit and word/mask/pulse-length operand.
interface bit_ctrl_bank_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BIT_W = $clog2(WIDTH);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CH_W-1:0]  cmd_ch;
  logic [BIT_W-1:0] cmd_bit;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_bit, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_bit, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/bit_ctrl_bank.sv
// bit_ctrl_bank: CHANNELS independent WIDTH-bit output registers driven by a
// command port (set/clear/toggle/load/mask ops and a timed self-clearing
// single-bit pulse). Illegal commands are consumed and flagged on err.
// Optional feature: define BIT_CTRL_READBACK_EN to build the registered
// rd_data readback path; otherwise rd_data is tied to 0.
module bit_ctrl_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PULSE_W  = 4,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int BIT_W   = $clog2(WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  bit_ctrl_bank_if.slave            cmd,
  input  logic [CH_W-1:0]           rd_ch,
  output logic [WIDTH-1:0]          rd_data,
  output logic [CHANNELS*WIDTH-1:0] out_bits,
  output logic                      busy,
  output logic                      err
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_SET   = 3'd1,
    OP_CLR   = 3'd2,
    OP_TOG   = 3'd3,
    OP_LOAD  = 3'd4,
    OP_MSET  = 3'd5,
    OP_MCLR  = 3'd6,
    OP_PULSE = 3'd7
  } op_e;

  typedef enum logic {S_IDLE, S_PULSE} state_e;

  localparam logic [CH_W:0]  CH_LIMIT  = (CH_W+1)'(CHANNELS);
  localparam logic [BIT_W:0] BIT_LIMIT = (BIT_W+1)'(WIDTH);

  state_e             state;
  logic [WIDTH-1:0]   ch_regs [CHANNELS];
  logic [PULSE_W-1:0] cnt;
  logic [CH_W-1:0]    p_ch;
  logic [BIT_W-1:0]   p_bit;
  logic               ready_q;
  logic               err_q;

  op_e                op;
  logic               ch_ok;
  logic               bit_ok;
  logic               cmd_ok;
  logic [PULSE_W-1:0] pulse_len;
  logic [WIDTH-1:0]   bit_mask;
  logic [WIDTH-1:0]   word_cur;
  logic [WIDTH-1:0]   word_next;

  // Decode the command: legality checks and the channel word it would produce.
  always_comb begin
    op        = op_e'(cmd.cmd_op);
    ch_ok     = {1'b0, cmd.cmd_ch} < CH_LIMIT;
    bit_ok    = {1'b0, cmd.cmd_bit} < BIT_LIMIT;
    pulse_len = cmd.cmd_data[PULSE_W-1:0];
    bit_mask  = WIDTH'(1) << cmd.cmd_bit;
    word_cur  = ch_ok ? ch_regs[cmd.cmd_ch] : '0;
    cmd_ok    = ch_ok;
    if ((op == OP_SET) || (op == OP_CLR) || (op == OP_TOG) || (op == OP_PULSE))
      cmd_ok = cmd_ok && bit_ok;
    if ((op == OP_PULSE) && (pulse_len == '0))
      cmd_ok = 1'b0;
    case (op)
      OP_SET, OP_PULSE: word_next = word_cur | bit_mask;
      OP_CLR:           word_next = word_cur & ~bit_mask;
      OP_TOG:           word_next = word_cur ^ bit_mask;
      OP_LOAD:          word_next = cmd.cmd_data;
      OP_MSET:          word_next = word_cur | cmd.cmd_data;
      OP_MCLR:          word_next = word_cur & ~cmd.cmd_data;
      default:          word_next = word_cur;
    endcase
  end

  // Control FSM: applies accepted commands in IDLE, times out the pulse in PULSE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      p_ch    <= '0;
      p_bit   <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) ch_regs[c] <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            if (!cmd_ok) begin
              err_q <= 1'b1;
            end else if (op == OP_PULSE) begin
              ch_regs[cmd.cmd_ch] <= word_next;
              cnt                 <= pulse_len;
              p_ch                <= cmd.cmd_ch;
              p_bit               <= cmd.cmd_bit;
              state               <= S_PULSE;
              ready_q             <= 1'b0;
            end else if (op != OP_NOP) begin
              ch_regs[cmd.cmd_ch] <= word_next;
            end
          end
        end
        S_PULSE: begin
          if (cnt == PULSE_W'(1)) begin
            ch_regs[p_ch][p_bit] <= 1'b0;
            cnt                  <= '0;
            state                <= S_IDLE;
            ready_q              <= 1'b1;
          end else begin
            cnt <= cnt - PULSE_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Flatten the channel registers onto the output bus.
  always_comb begin
    out_bits = '0;
    for (int c = 0; c < CHANNELS; c++) out_bits[c*WIDTH +: WIDTH] = ch_regs[c];
  end

  assign cmd.cmd_ready = ready_q;
  assign busy          = !ready_q;
  assign err           = err_q;

`ifdef BIT_CTRL_READBACK_EN
  logic [WIDTH-1:0] rd_q;

  // Registered readback of the selected channel's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst)
      rd_q <= '0;
    else if ({1'b0, rd_ch} < CH_LIMIT)
      rd_q <= ch_regs[rd_ch];
    else
      rd_q <= '0;
  end

  assign rd_data = rd_q;
`else
  logic unused_rd_ch;
  assign unused_rd_ch = ^rd_ch;
  assign rd_data      = '0;
`endif

endmodule

// File: tb/tb_bit_ctrl_bank.sv
// Testbench for bit_ctrl_bank. Built with WIDTH=10, CHANNELS=5 so that both
// out-of-range channel and out-of-range bit rejections are reachable.
module tb_bit_ctrl_bank;
  localparam int WIDTH    = 10;
  localparam int CHANNELS = 5;
  localparam int PULSE_W  = 4;
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BIT_W    = $clog2(WIDTH);

  logic                      clk = 1'b0;
  logic                      rst;
  logic [CH_W-1:0]           rd_ch;
  logic [WIDTH-1:0]          rd_data;
  logic [CHANNELS*WIDTH-1:0] out_bits;
  logic                      busy;
  logic                      err;

  bit_ctrl_bank_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) cmd_if ();

  bit_ctrl_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PULSE_W(PULSE_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_if),
    .rd_ch    (rd_ch),
    .rd_data  (rd_data),
    .out_bits (out_bits),
    .busy     (busy),
    .err      (err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: register contents plus the edge index at which a running
  // pulse ends.
  int unsigned m_reg [CHANNELS];
  bit          m_active;
  int          m_end;
  int          m_pch;
  int          m_pbit;
  bit          m_err;
  int          m_cyc;
  int unsigned m_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model_bus();
    logic [63:0] b = '0;
    for (int c = 0; c < CHANNELS; c++) b = b | (64'(m_reg[c]) << (c * WIDTH));
    return b;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) m_reg[c] = 0;
    m_active = 0;
    m_err    = 0;
    m_rd     = 0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input bit v, input int op, input int ch, input int bt,
                            input int unsigned data, input int rd, input bit r);
    int unsigned mask;
    int          len;
    bit          legal;
    m_cyc++;
`ifdef BIT_CTRL_READBACK_EN
    m_rd = (rd < CHANNELS) ? m_reg[rd] : 0;
`else
    m_rd = 0;
`endif
    if (r) begin
      model_reset();
      return;
    end
    m_err = 0;
    if (m_active) begin
      if (m_cyc == m_end) begin
        m_reg[m_pch] = m_reg[m_pch] & ~(1 << m_pbit);
        m_active     = 0;
      end
      return;
    end
    if (!v) return;
    len   = data % (1 << PULSE_W);
    legal = (ch < CHANNELS);
    if ((op >= 1 && op <= 3) || op == 7) legal = legal && (bt < WIDTH);
    if (op == 7 && len == 0) legal = 0;
    if (!legal) begin
      m_err = 1;
      return;
    end
    mask = 1 << bt;
    case (op)
      1: m_reg[ch] = m_reg[ch] | mask;
      2: m_reg[ch] = m_reg[ch] & ~mask;
      3: m_reg[ch] = m_reg[ch] ^ mask;
      4: m_reg[ch] = data;
      5: m_reg[ch] = m_reg[ch] | data;
      6: m_reg[ch] = m_reg[ch] & ~data;
      7: begin
        m_reg[ch] = m_reg[ch] | mask;
        m_active  = 1;
        m_end     = m_cyc + len;
        m_pch     = ch;
        m_pbit    = bt;
      end
      default: ;
    endcase
  endtask

  task automatic check_output();
    check("out_bits",  64'(out_bits), model_bus());
    check("cmd_ready", 64'(cmd_if.cmd_ready), 64'(!m_active));
    check("busy",      64'(busy), 64'(m_active));
    check("err",       64'(err), 64'(m_err));
    check("rd_data",   64'(rd_data), 64'(m_rd));
  endtask

  // Drive one cycle of inputs, advance the model and DUT by one edge, compare.
  task automatic apply_stimulus(input bit v, input int op, input int ch, input int bt,
                                input int unsigned data, input int rd, input bit r);
    int unsigned dw;
    @(negedge clk);
    dw               = data & ((1 << WIDTH) - 1);
    rst              = r;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op[2:0];
    cmd_if.cmd_ch    = ch[CH_W-1:0];
    cmd_if.cmd_bit   = bt[BIT_W-1:0];
    cmd_if.cmd_data  = dw[WIDTH-1:0];
    rd_ch            = rd[CH_W-1:0];
    model_edge(v, op, ch, bt, dw, rd, r);
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op = '0;
    cmd_if.cmd_ch = '0;
    cmd_if.cmd_bit = '0;
    cmd_if.cmd_data = '0;
    rd_ch = '0;

    // Reset, then idle.
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    idle(5);
    check("reset_out_bits", 64'(out_bits), 64'h0);
    check("reset_ready", 64'(cmd_if.cmd_ready), 64'h1);

    // Back-to-back single-bit and mask ops on channel 2.
    apply_stimulus(1, 4, 2, 0, 'hA5, 2, 0);
    check("ch2_load", 64'(out_bits[2*WIDTH +: WIDTH]), 64'hA5);
    apply_stimulus(1, 1, 2, 1, 0, 2, 0);
    check("ch2_set", 64'(out_bits[2*WIDTH +: WIDTH]), 64'hA7);
    apply_stimulus(1, 3, 2, 7, 0, 2, 0);
    check("ch2_tog", 64'(out_bits[2*WIDTH +: WIDTH]), 64'h27);
    apply_stimulus(1, 6, 2, 0, 'h0F, 2, 0);
    check("ch2_mclr", 64'(out_bits[2*WIDTH +: WIDTH]), 64'h20);
    check("other_ch", 64'(out_bits) & ~(64'h3FF << (2*WIDTH)), 64'h0);
    idle(1);

    // Pulse ch1 bit3 for 3 cycles with a SET ch1 bit0 held valid throughout.
    apply_stimulus(1, 7, 1, 3, 3, 1, 0);
    check("pulse_hi0", 64'(out_bits[WIDTH+3]), 64'h1);
    for (int i = 1; i <= 3; i++) begin
      apply_stimulus(1, 1, 1, 0, 0, 1, 0);
      check("pulse_bit", 64'(out_bits[WIDTH+3]), (i < 3) ? 64'h1 : 64'h0);
      check("pulse_set_held", 64'(out_bits[WIDTH+0]), 64'h0);
    end
    apply_stimulus(1, 1, 1, 0, 0, 1, 0);
    check("set_after_pulse", 64'(out_bits[WIDTH+0]), 64'h1);
    idle(1);

    // Rejections: channel out of range, bit out of range, zero-length pulse.
    apply_stimulus(1, 4, 5, 0, 'h3FF, 0, 0);
    check("rej_ch_err", 64'(err), 64'h1);
    apply_stimulus(1, 1, 0, 12, 0, 0, 0);
    check("rej_bit_err", 64'(err), 64'h1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check("err_clears", 64'(err), 64'h0);
    apply_stimulus(1, 7, 0, 2, 'h30, 0, 0);
    check("rej_len0_err", 64'(err), 64'h1);
    idle(2);

    // Reset on the second cycle of a length-5 pulse, then re-set the bit.
    apply_stimulus(1, 7, 4, 6, 5, 4, 0);
    apply_stimulus(0, 0, 0, 0, 0, 4, 0);
    apply_stimulus(0, 0, 0, 0, 0, 4, 1);
    check("rst_mid_pulse", 64'(out_bits), 64'h0);
    check("rst_ready", 64'(cmd_if.cmd_ready), 64'h1);
    apply_stimulus(1, 1, 4, 6, 0, 4, 0);
    idle(6);
    check("no_stale_clear", 64'(out_bits[4*WIDTH+6]), 64'h1);

    // Reset and valid on the same edge: command dropped.
    apply_stimulus(1, 4, 0, 0, 'h155, 0, 1);
    check("rst_drops_cmd", 64'(out_bits), 64'h0);

    // Readback.
    apply_stimulus(1, 4, 3, 0, 'h3C, 3, 0);
    apply_stimulus(0, 0, 0, 0, 0, 3, 0);
`ifdef BIT_CTRL_READBACK_EN
    check("readback", 64'(rd_data), 64'h3C);
`else
    check("readback_off", 64'(rd_data), 64'h0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      apply_stimulus(($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                     $urandom, int'($urandom_range(0, 7)),
                     ($urandom_range(0, 79) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
